// File: rtl/sc_ctrl_pkg.sv
// Shared types and reset constants for the SC decoder status controller.
package sc_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } ctrl_state_e;

    // Flushed delay-line entries hold bit 0 of the deepest stage (N-1).
    localparam int unsigned RstBit = 0;

    function automatic int unsigned rst_stage(input int unsigned n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/sc_index_delay.sv
// PIPE_DEPTH-deep shift register for the {valid, stage, bit} schedule stream,
// aligning the scheduler indices with the datapath output.
module sc_index_delay
    import sc_ctrl_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned STAGE_W    = 2,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [STAGE_W-1:0] in_stage,
    input  logic [N-1:0]       in_bit,
    output logic               out_valid,
    output logic [STAGE_W-1:0] out_stage,
    output logic [N-1:0]       out_bit
);

    localparam logic [STAGE_W-1:0] RstStageVal = STAGE_W'(rst_stage(N));
    localparam logic [N-1:0]       RstBitVal   = N'(RstBit);

    logic               vld_q [PIPE_DEPTH];
    logic [STAGE_W-1:0] stg_q [PIPE_DEPTH];
    logic [N-1:0]       bit_q [PIPE_DEPTH];

    // Shift the index stream by one stage per cycle; reset and flush clear it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                stg_q[i] <= RstStageVal;
                bit_q[i] <= RstBitVal;
            end
        end else begin
            vld_q[0] <= in_valid;
            stg_q[0] <= in_stage;
            bit_q[0] <= in_bit;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                stg_q[i] <= stg_q[i-1];
                bit_q[i] <= bit_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[PIPE_DEPTH-1];
    assign out_stage = stg_q[PIPE_DEPTH-1];
    assign out_bit   = bit_q[PIPE_DEPTH-1];

endmodule

// File: rtl/sc_status_controller.sv
// Status controller for the semi-parallel SC decoder: frame FSM, one-deep
// start queue, abort, overrun flag and completed-frame counter.
module sc_status_controller
    import sc_ctrl_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned STAGE_W    = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned FRAME_ID_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  abort,
    input  logic                  idx_valid,
    input  logic [STAGE_W-1:0]    stage_index,
    input  logic [N-1:0]          bit_index,
    output logic                  decoder_busy,
    output logic                  decoder_done,
    output logic                  data_valid,
    output logic [FRAME_ID_W-1:0] frame_id,
    output logic                  start_pending,
    output logic                  overrun
);

    localparam logic [N-1:0] LastBit = '1;

    ctrl_state_e           state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic [FRAME_ID_W-1:0] fid_q, fid_d;

    logic               d_valid;
    logic [STAGE_W-1:0] d_stage;
    logic [N-1:0]       d_bit;
    logic               last;

    sc_index_delay #(
        .N          (N),
        .STAGE_W    (STAGE_W),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_index_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (idx_valid),
        .in_stage  (stage_index),
        .in_bit    (bit_index),
        .out_valid (d_valid),
        .out_stage (d_stage),
        .out_bit   (d_bit)
    );

    assign data_valid = d_valid && (d_stage == '0);
    assign last       = data_valid && (d_bit == LastBit);

    // Next state, start queue, overrun and frame counter; abort beats last beats en.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        fid_d     = fid_q;
        unique case (state_q)
            StIdle: begin
                if (!abort && en) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (abort) begin
                    state_d   = StIdle;
                    pending_d = 1'b0;
                end else begin
                    if (last) begin
                        state_d = StDone;
                        fid_d   = fid_q + 1'b1;
                    end
                    // A start arriving with last still queues for the next frame.
                    if (en) begin
                        if (!pending_q) begin
                            pending_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                pending_d = 1'b0;
                if (abort) begin
                    state_d = StIdle;
                end else if (pending_q || en) begin
                    state_d = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            fid_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            fid_q     <= fid_d;
        end
    end

    assign decoder_busy  = (state_q == StBusy);
    assign decoder_done  = (state_q == StDone);
    assign frame_id      = fid_q;
    assign start_pending = pending_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sc_status_controller.sv
// Directed self-checking bench for sc_status_controller (N=3, PIPE_DEPTH=2, FRAME_ID_W=2).
module tb_sc_status_controller;

    localparam int unsigned N          = 3;
    localparam int unsigned STAGE_W    = 2;
    localparam int unsigned PIPE_DEPTH = 2;
    localparam int unsigned FRAME_ID_W = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en = 1'b0;
    logic                  abort = 1'b0;
    logic                  idx_valid = 1'b0;
    logic [STAGE_W-1:0]    stage_index = '0;
    logic [N-1:0]          bit_index = '0;
    logic                  decoder_busy;
    logic                  decoder_done;
    logic                  data_valid;
    logic [FRAME_ID_W-1:0] frame_id;
    logic                  start_pending;
    logic                  overrun;

    int checks = 0;
    int failures = 0;
    logic [FRAME_ID_W-1:0] exp_fid = '0;

    sc_status_controller #(
        .N          (N),
        .STAGE_W    (STAGE_W),
        .PIPE_DEPTH (PIPE_DEPTH),
        .FRAME_ID_W (FRAME_ID_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .abort         (abort),
        .idx_valid     (idx_valid),
        .stage_index   (stage_index),
        .bit_index     (bit_index),
        .decoder_busy  (decoder_busy),
        .decoder_done  (decoder_done),
        .data_valid    (data_valid),
        .frame_id      (frame_id),
        .start_pending (start_pending),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idx(input logic v, input logic [STAGE_W-1:0] s, input logic [N-1:0] b);
        idx_valid   = v;
        stage_index = s;
        bit_index   = b;
    endtask

    task automatic pulse_en();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    // Push the final index (stage 0, bit 7) and wait until it reaches the delay output.
    task automatic send_last();
        set_idx(1'b1, 2'd0, 3'd7);
        tick();
        set_idx(1'b0, 2'd0, 3'd0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", decoder_busy); end
        checks++; if (decoder_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", decoder_done); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_dv: got %b expected 0", data_valid); end
        checks++; if (frame_id !== 2'd0) begin failures++; $display("FAIL rst_fid: got %0d expected 0", frame_id); end
        checks++; if (start_pending !== 1'b0) begin failures++; $display("FAIL rst_pending: got %b expected 0", start_pending); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        tick();
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL idle_stays: got %b expected 0", decoder_busy); end
    endtask

    task automatic test_single_frame();
        pulse_en();
        checks++; if (decoder_busy !== 1'b1) begin failures++; $display("FAIL sf_busy: got %b expected 1", decoder_busy); end
        set_idx(1'b1, 2'd1, 3'd5);
        tick();
        set_idx(1'b1, 2'd1, 3'd6);
        tick();
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL sf_dv_stage1a: got %b expected 0", data_valid); end
        set_idx(1'b1, 2'd0, 3'd3);
        tick();
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL sf_dv_stage1b: got %b expected 0", data_valid); end
        set_idx(1'b1, 2'd0, 3'd4);
        tick();
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL sf_dv_first: got %b expected 1", data_valid); end
        set_idx(1'b0, 2'd0, 3'd0);
        tick();
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL sf_dv_second: got %b expected 1", data_valid); end
        checks++; if (decoder_done !== 1'b0) begin failures++; $display("FAIL sf_early_done: got %b expected 0", decoder_done); end
        tick();
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL sf_dv_drop: got %b expected 0", data_valid); end
        set_idx(1'b1, 2'd0, 3'd7);
        tick();
        set_idx(1'b0, 2'd0, 3'd0);
        checks++; if (decoder_busy !== 1'b1) begin failures++; $display("FAIL sf_busy_mid: got %b expected 1", decoder_busy); end
        tick();
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL sf_dv_last: got %b expected 1", data_valid); end
        checks++; if (decoder_done !== 1'b0) begin failures++; $display("FAIL sf_done_early: got %b expected 0", decoder_done); end
        tick();
        exp_fid = exp_fid + 1'b1;
        checks++; if (decoder_done !== 1'b1) begin failures++; $display("FAIL sf_done: got %b expected 1", decoder_done); end
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL sf_busy_done: got %b expected 0", decoder_busy); end
        checks++; if (frame_id !== exp_fid) begin failures++; $display("FAIL sf_fid: got %0d expected %0d", frame_id, exp_fid); end
        tick();
        checks++; if (decoder_done !== 1'b0) begin failures++; $display("FAIL sf_done_pulse: got %b expected 0", decoder_done); end
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL sf_idle: got %b expected 0", decoder_busy); end
    endtask

    task automatic test_back_to_back();
        pulse_en();
        pulse_en();
        checks++; if (start_pending !== 1'b1) begin failures++; $display("FAIL b2b_pending: got %b expected 1", start_pending); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun: got %b expected 0", overrun); end
        send_last();
        tick();
        exp_fid = exp_fid + 1'b1;
        checks++; if (decoder_done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b expected 1", decoder_done); end
        checks++; if (frame_id !== exp_fid) begin failures++; $display("FAIL b2b_fid1: got %0d expected %0d", frame_id, exp_fid); end
        tick();
        checks++; if (decoder_busy !== 1'b1) begin failures++; $display("FAIL b2b_restart: got %b expected 1", decoder_busy); end
        checks++; if (start_pending !== 1'b0) begin failures++; $display("FAIL b2b_pending_clr: got %b expected 0", start_pending); end
        checks++; if (decoder_done !== 1'b0) begin failures++; $display("FAIL b2b_done_clr: got %b expected 0", decoder_done); end
        send_last();
        tick();
        exp_fid = exp_fid + 1'b1;
        checks++; if (frame_id !== exp_fid) begin failures++; $display("FAIL b2b_fid2: got %0d expected %0d", frame_id, exp_fid); end
        tick();
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b expected 0", decoder_busy); end
    endtask

    task automatic test_overrun();
        pulse_en();
        pulse_en();
        pulse_en();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse: got %b expected 1", overrun); end
        checks++; if (start_pending !== 1'b1) begin failures++; $display("FAIL ovr_pending: got %b expected 1", start_pending); end
        tick();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_one_cycle: got %b expected 0", overrun); end
        send_last();
        tick();
        tick();
        checks++; if (decoder_busy !== 1'b1) begin failures++; $display("FAIL ovr_queued: got %b expected 1", decoder_busy); end
        send_last();
        tick();
        tick();
        exp_fid = exp_fid + 2'd2;
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL ovr_single_queue: got %b expected 0", decoder_busy); end
        checks++; if (frame_id !== exp_fid) begin failures++; $display("FAIL ovr_fid: got %0d expected %0d", frame_id, exp_fid); end
    endtask

    task automatic test_abort();
        pulse_en();
        pulse_en();
        set_idx(1'b1, 2'd0, 3'd7);
        tick();
        set_idx(1'b0, 2'd0, 3'd0);
        tick();
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL abort_dv_before: got %b expected 1", data_valid); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", decoder_busy); end
        checks++; if (decoder_done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", decoder_done); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL abort_dv: got %b expected 0", data_valid); end
        checks++; if (start_pending !== 1'b0) begin failures++; $display("FAIL abort_pending: got %b expected 0", start_pending); end
        checks++; if (frame_id !== exp_fid) begin failures++; $display("FAIL abort_fid: got %0d expected %0d", frame_id, exp_fid); end
        tick();
        tick();
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL abort_no_restart: got %b expected 0", decoder_busy); end
    endtask

    task automatic test_wrap_and_rst();
        logic [FRAME_ID_W-1:0] exp_seq [5];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pulse_en();
            send_last();
            tick();
            checks++; if (decoder_done !== 1'b1) begin failures++; $display("FAIL wrap_done%0d: got %b expected 1", k, decoder_done); end
            checks++; if (frame_id !== exp_seq[k]) begin failures++; $display("FAIL wrap_fid%0d: got %0d expected %0d", k, frame_id, exp_seq[k]); end
            tick();
        end
        pulse_en();
        pulse_en();
        set_idx(1'b1, 2'd0, 3'd7);
        tick();
        set_idx(1'b0, 2'd0, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (decoder_busy !== 1'b0) begin failures++; $display("FAIL mrst_busy: got %b expected 0", decoder_busy); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL mrst_dv: got %b expected 0", data_valid); end
        checks++; if (frame_id !== 2'd0) begin failures++; $display("FAIL mrst_fid: got %0d expected 0", frame_id); end
        checks++; if (start_pending !== 1'b0) begin failures++; $display("FAIL mrst_pending: got %b expected 0", start_pending); end
        tick();
        tick();
        checks++; if (decoder_done !== 1'b0) begin failures++; $display("FAIL mrst_no_done: got %b expected 0", decoder_done); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_wrap_and_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_status_controller.md
# sc_status_controller

Parametrised status controller for the semi-parallel SC decoder family. It tracks the decoding schedule's (stage_index, bit_index) stream through a configurable-depth delay line matching the datapath latency, and drives decoder_busy, decoder_done and data_valid. Over the previous controller it adds an explicit FSM, a one-deep start queue for back-to-back frames, abort, an overrun flag and a frame counter. It sits between the bit-reversed input buffer (start request) and the output/bit-collection logic.

## Interface
Parameters:
- N, 3: log2 of code length; bit_index is N bits; last bit = 2**N-1.
- STAGE_W, $clog2(N) (min 1): stage_index width.
- PIPE_DEPTH, 2 (>=1): index delay, cycles, matching datapath latency.
- FRAME_ID_W, 4: frame counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  start request (buffer ready), single-cycle or level.
- abort  in  1  terminate current frame without done.
- idx_valid  in  1  stage_index/bit_index valid this cycle.
- stage_index  in  STAGE_W  current stage from scheduler.
- bit_index  in  N  current bit from scheduler.
- decoder_busy  out  1  frame in progress.
- decoder_done  out  1  one-cycle pulse, frame complete.
- data_valid  out  1  delayed index at stage 0 (decided bit valid).
- frame_id  out  FRAME_ID_W  count of completed frames, wraps.
- start_pending  out  1  start request queued while busy.
- overrun  out  1  one-cycle pulse, start request dropped.

## Operation
- Delay line: PIPE_DEPTH registers of {valid, stage, bit}; reset/flush values valid=0, stage=N-1, bit=0. Outputs d_valid, d_stage, d_bit.
- data_valid = d_valid && d_stage==0 (combinational from delay output).
- last = d_valid && d_stage==0 && d_bit==2**N-1.
- FSM states IDLE, BUSY, DONE; decoder_busy = (state==BUSY), decoder_done = (state==DONE), both registered.
- IDLE: en -> BUSY. last ignored.
- BUSY: abort -> IDLE, delay line flushed, start_pending cleared, frame_id unchanged. Else last -> DONE, frame_id+1 (mod 2**FRAME_ID_W). en while BUSY: if !start_pending, set start_pending; else overrun pulse, request dropped. en on the same cycle as last is queued, as above.
- DONE (exactly one cycle): start_pending or en -> BUSY, start_pending cleared; else IDLE. abort in DONE -> IDLE, pending cleared, done pulse still emitted.
- Priority: rst > abort > last > en.
- rst mid-frame: all state to reset values next edge; no done pulse.

## Timing
- Reset values: decoder_busy=0, decoder_done=0, data_valid=0, frame_id=0, start_pending=0, overrun=0, state IDLE.
- en at cycle t in IDLE -> decoder_busy=1 at t+1.
- Index sampled at t with idx_valid -> visible at delay output (data_valid) at t+PIPE_DEPTH.
- Last index (stage 0, bit 2**N-1) at t -> last at t+PIPE_DEPTH -> decoder_done=1, decoder_busy=0, frame_id incremented at t+PIPE_DEPTH+1.
- Back-to-back with pending start: decoder_busy=1 again at t+PIPE_DEPTH+2 (one-cycle gap).
- abort at t -> decoder_busy=0 and data_valid=0 at t+1.
- overrun is high for one cycle, in the cycle after the dropped en.

## Structure
- Package sc_ctrl_pkg: state enum (IDLE, BUSY, DONE), reset-value constants for the delay line (stage N-1, bit 0).
- Sub-module sc_index_delay: parametrised PIPE_DEPTH shift register with synchronous flush. FSM and counters stay in the top module.

## Test plan
- N=3, PIPE_DEPTH=2: reset, en at cycle 5, schedule ends with stage 0/bit 7 at cycle 40 -> busy 1 at 6, done pulse at 43, busy 0 at 43, frame_id 0->1.
- data_valid: stage 0 indices at cycles 10,11 -> data_valid high at 12,13 only; stage 1 indices never raise it.
- Back-to-back: en pulses at cycle 20 while busy -> start_pending=1; done at 43 -> busy 1 at 44, pending 0.
- Overrun: two en pulses while busy -> second gives overrun=1 for one cycle, single queued frame only.
- Abort at cycle 30 mid-frame -> busy 0 at 31, no done, frame_id unchanged, data_valid 0 at 31.
- FRAME_ID_W=2: 5 complete frames -> frame_id 1,2,3,0,1; rst mid-frame -> all outputs 0 next edge.
